mem_access_unit: RTL

Load/store sequencer between the core's memory stage and the single-port word memory (1-cycle synchronous read, whole-word write, byte address internally shifted right by 2). Accepts one load or store per handshake. Performs byte and halfword extraction with sign or zero extension on loads. Implements sub-word stores as read-modify-write, because the memory only writes whole words.

---
 rtl/mau_pkg.sv | 61 ++++++
 rtl/load_extract.sv | 46 ++++
 rtl/mem_access_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mau_pkg.sv
// ============================================================================
// Module : mau_pkg
// Brief  : Shared types, funct3 codes and lane helpers for mem_access_unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mau_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD_RD   = 3'd1,
        LD_RESP = 3'd2,
        ST_WR   = 3'd3,
        RMW_RD  = 3'd4,
`ifdef MAU_MISALIGN_TRAP_EN
        RMW_WR  = 3'd5,
        ERR     = 3'd6
`else
        RMW_WR  = 3'd5
`endif
    } mau_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic is_half(input logic [2:0] f3);
        return f3[1:0] == 2'b01;
    endfunction

    function automatic logic is_byte(input logic [2:0] f3);
        return f3[1:0] == 2'b00;
    endfunction

    // Byte lane of the low end of the access; halfwords snap to an even lane.
    function automatic logic [1:0] eff_lane(input logic [2:0] f3, input logic [1:0] a);
        if (is_byte(f3))
            return a;
        else if (is_half(f3))
            return {a[1], 1'b0};
        else
            return 2'b00;
    endfunction

    function automatic logic is_illegal(input logic store, input logic [2:0] f3);
        if (store)
            return f3 > F3_W;
        else
            return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        return (is_half(f3) && a[0]) || ((f3 == F3_W) && (a != 2'b00));
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_extract.sv
// ============================================================================
// Module : load_extract
// Brief  : Lane select with sign/zero extension for byte/half/word loads.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module load_extract
    import mau_pkg::*;
(
    input  logic [2:0]  f3,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    output logic [31:0] rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word[7:0];
        case (lane)
            2'd1:    w_byte = word[15:8];
            2'd2:    w_byte = word[23:16];
            2'd3:    w_byte = word[31:24];
            default: w_byte = word[7:0];
        endcase
    end

    // Odd halfword lanes fold onto the enclosing even lane.
    assign w_half = lane[1] ? word[31:16] : word[15:0];

    always_comb begin
        rdata = word;
        case (f3)
            F3_B:    rdata = {{24{w_byte[7]}}, w_byte};
            F3_H:    rdata = {{16{w_half[15]}}, w_half};
            F3_BU:   rdata = {24'd0, w_byte};
            F3_HU:   rdata = {16'd0, w_half};
            default: rdata = word;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module : mem_access_unit
// Brief  : Load/store sequencer with sub-word extraction and RMW stores.
//          Optional MAU_MISALIGN_TRAP_EN routes misaligned/illegal requests
//          to an error response.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_unit
    import mau_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_r_addr,
    input  logic [31:0] mem_r_data,
    output logic [31:0] mem_w_addr,
    output logic [31:0] mem_w_data
);

    mau_state_t  r_state;
    mau_state_t  w_next;
    logic        r_op;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    logic [31:0] r_wd;

    logic [2:0]  w_ld_f3;
    logic [31:0] w_ld_data;
    logic [31:0] w_mask_raw;
    logic [31:0] w_mask;
    logic [4:0]  w_shamt;
    logic [31:0] w_merge;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_op    <= 1'b0;
            r_f3    <= 3'd0;
            r_addr  <= 32'd0;
            r_wd    <= 32'd0;
        end else begin
            r_state <= w_next;
            if ((r_state == IDLE) && req_valid) begin
                r_op   <= req_store;
                r_f3   <= req_funct3;
                r_addr <= req_addr;
                r_wd   <= req_wdata;
            end
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign mem_r_addr = {r_addr[31:2], 2'b00};
    assign mem_w_addr = {r_addr[31:2], 2'b00};

    // Illegal load codes behave as LW when they are not trapped.
    assign w_ld_f3 = is_illegal(1'b0, r_f3) ? F3_W : r_f3;

    load_extract u_load (
        .f3    (w_ld_f3),
        .lane  (r_addr[1:0]),
        .word  (mem_r_data),
        .rdata (w_ld_data)
    );

    // Extracting from an all-ones word yields the 0xFF / 0xFFFF field mask.
    load_extract u_mask (
        .f3    (is_half(r_f3) ? F3_HU : F3_BU),
        .lane  (2'b00),
        .word  (32'hFFFF_FFFF),
        .rdata (w_mask_raw)
    );

    assign w_shamt = {eff_lane(r_f3, r_addr[1:0]), 3'b000};
    assign w_mask  = w_mask_raw << w_shamt;
    assign w_merge = (mem_r_data & ~w_mask) | ((r_wd << w_shamt) & w_mask);

    always_comb begin
        w_next     = r_state;
        mem_we     = 1'b0;
        mem_w_data = r_wd;
        resp_valid = 1'b0;
        resp_rdata = 32'd0;
        resp_err   = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
`ifdef MAU_MISALIGN_TRAP_EN
                    if (is_illegal(req_store, req_funct3) ||
                        is_misaligned(req_funct3, req_addr[1:0]))
                        w_next = ERR;
                    else
`endif
                    if (!req_store)
                        w_next = LD_RD;
                    else if ((req_funct3 == F3_B) || (req_funct3 == F3_H))
                        w_next = RMW_RD;
                    else
                        w_next = ST_WR;
                end
            end
            LD_RD: w_next = LD_RESP;
            LD_RESP: begin
                w_next     = IDLE;
                resp_valid = 1'b1;
                resp_rdata = r_op ? 32'd0 : w_ld_data;
            end
            ST_WR: begin
                w_next     = IDLE;
                mem_we     = 1'b1;
                resp_valid = 1'b1;
            end
            RMW_RD: w_next = RMW_WR;
            RMW_WR: begin
                w_next     = IDLE;
                mem_we     = 1'b1;
                mem_w_data = w_merge;
                resp_valid = 1'b1;
            end
`ifdef MAU_MISALIGN_TRAP_EN
            ERR: begin
                w_next     = IDLE;
                resp_valid = 1'b1;
                resp_err   = 1'b1;
            end
`endif
            default: w_next = IDLE;
        endcase
    end

endmodule

`default_nettype wire
